// File: rtl/ibex_pmp_chan_arb.sv
// ibex_pmp_chan_arb
// Shares one PMP check channel between the instruction-fetch (I) and
// load/store (D) requesters. One request is accepted at a time. The checker
// inputs (pmp_*_o) are driven from latched state. The checker's combinational
// error result is sampled in CHECK, and also in CHECK2 for word-crossing D
// accesses. The merged result is returned as a one-cycle response pulse.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ireq_*                       I-side request (valid/ready/addr/priv)
//   dreq_*                       D-side request (valid/ready/addr/type/priv/split)
//   irsp_*, drsp_*               response pulse + error flag per requester
//   flush_i                      cancels an outstanding I-side check
//   pmp_addr_o/type_o/priv_o     checker channel inputs
//   pmp_err_i                    checker error for the current pmp_*_o

package ibex_pkg;
    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;
endpackage

module ibex_pmp_chan_arb #(
    parameter int unsigned StarveLimit = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ireq_valid_i,
    output logic                 ireq_ready_o,
    input  logic [33:0]          ireq_addr_i,
    input  ibex_pkg::priv_lvl_e  ireq_priv_i,
    input  logic                 dreq_valid_i,
    output logic                 dreq_ready_o,
    input  logic [33:0]          dreq_addr_i,
    input  ibex_pkg::pmp_req_e   dreq_type_i,
    input  ibex_pkg::priv_lvl_e  dreq_priv_i,
    input  logic                 dreq_split_i,
    output logic                 irsp_valid_o,
    output logic                 irsp_err_o,
    output logic                 drsp_valid_o,
    output logic                 drsp_err_o,
    input  logic                 flush_i,
    output logic [33:0]          pmp_addr_o,
    output ibex_pkg::pmp_req_e   pmp_type_o,
    output ibex_pkg::priv_lvl_e  pmp_priv_o,
    input  logic                 pmp_err_i
);
    import ibex_pkg::*;

    localparam logic [3:0] StarveMax = 4'(StarveLimit);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CHECK  = 2'b01,
        ST_CHECK2 = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [33:0] addr_q, addr_d;
    pmp_req_e    type_q, type_d;
    priv_lvl_e   priv_q, priv_d;
    logic        split_q, split_d;
    logic        own_d_q, own_d_d;     // 1: D-side owns the operation
    logic        err_q, err_d;
    logic        last_d_q, last_d_d;   // 1: last grant went to the D-side
    logic [3:0]  starve_q, starve_d;

    logic        grant_ok_s;
    logic        starve_hit_s;
    logic        gnt_i_s;
    logic        gnt_d_s;
    logic        flush_own_s;

    // Grant arbitration: round-robin on ties, starvation override for the I-side.
    always_comb begin
        grant_ok_s   = (state_q == ST_IDLE) || (state_q == ST_RESP);
        starve_hit_s = (starve_q >= StarveMax);
        gnt_i_s      = 1'b0;
        gnt_d_s      = 1'b0;
        if (!grant_ok_s) begin
            gnt_i_s = 1'b0;
            gnt_d_s = 1'b0;
        end else if (ireq_valid_i && dreq_valid_i) begin
            if (starve_hit_s || last_d_q) begin
                gnt_i_s = 1'b1;
            end else begin
                gnt_d_s = 1'b1;
            end
        end else begin
            gnt_i_s = ireq_valid_i;
            gnt_d_s = dreq_valid_i;
        end
    end

    // Next-state, request latching, error accumulation and starvation tracking.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        type_d      = type_q;
        priv_d      = priv_q;
        split_d     = split_q;
        own_d_d     = own_d_q;
        err_d       = err_q;
        last_d_d    = last_d_q;
        starve_d    = starve_q;
        flush_own_s = flush_i && !own_d_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (gnt_i_s || gnt_d_s) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                err_d = pmp_err_i;
                if (flush_own_s) begin
                    state_d = ST_IDLE;
                end else if (split_q) begin
                    state_d = ST_CHECK2;
                    // Next word; the 32-bit word index wraps naturally.
                    addr_d  = {addr_q[33:2] + 32'd1, 2'b00};
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_CHECK2: begin
                err_d = err_q | pmp_err_i;
                if (flush_own_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (gnt_i_s) begin
            addr_d   = ireq_addr_i;
            type_d   = PMP_ACC_EXEC;
            priv_d   = ireq_priv_i;
            split_d  = 1'b0;
            own_d_d  = 1'b0;
            last_d_d = 1'b0;
            starve_d = 4'd0;
        end else if (gnt_d_s) begin
            addr_d   = dreq_addr_i;
            type_d   = dreq_type_i;
            priv_d   = dreq_priv_i;
            split_d  = dreq_split_i;
            own_d_d  = 1'b1;
            last_d_d = 1'b1;
            if (!ireq_valid_i) begin
                starve_d = 4'd0;
            end else if (starve_hit_s) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + 4'd1;
            end
        end else begin
            last_d_d = last_d_q;
        end
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= 34'd0;
            type_q   <= PMP_ACC_READ;
            priv_q   <= PRIV_LVL_M;
            split_q  <= 1'b0;
            own_d_q  <= 1'b0;
            err_q    <= 1'b0;
            last_d_q <= 1'b1;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            type_q   <= type_d;
            priv_q   <= priv_d;
            split_q  <= split_d;
            own_d_q  <= own_d_d;
            err_q    <= err_d;
            last_d_q <= last_d_d;
            starve_q <= starve_d;
        end
    end

    assign ireq_ready_o = gnt_i_s;
    assign dreq_ready_o = gnt_d_s;

    // Responses decode straight from registered state; error is gated so it
    // only ever reads high alongside its valid pulse.
    assign irsp_valid_o = (state_q == ST_RESP) && !own_d_q;
    assign drsp_valid_o = (state_q == ST_RESP) && own_d_q;
    assign irsp_err_o   = irsp_valid_o && err_q;
    assign drsp_err_o   = drsp_valid_o && err_q;

    assign pmp_addr_o = addr_q;
    assign pmp_type_o = type_q;
    assign pmp_priv_o = priv_q;

endmodule

// File: tb/tb_ibex_pmp_chan_arb.sv
// Directed bench for ibex_pmp_chan_arb (StarveLimit = 2). A per-cycle vector
// table covers reset values, single I/D checks, split merging, word wrap and
// back-to-back grants. Hand sequences cover round-robin, starvation bound,
// flush and mid-operation reset. The PMP checker is modelled as "error when
// pmp_addr_o equals err_addr and err_en is set".
module tb_ibex_pmp_chan_arb;
    import ibex_pkg::*;

    localparam logic [1:0] EX = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] PM = 2'b11;
    localparam logic [1:0] PU = 2'b00;
    localparam logic [1:0] PS = 2'b01;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ireq_valid, ireq_ready;
    logic [33:0] ireq_addr;
    logic        dreq_valid, dreq_ready;
    logic [33:0] dreq_addr;
    pmp_req_e    dreq_type;
    logic        dreq_split;
    logic        irsp_valid, irsp_err, drsp_valid, drsp_err;
    logic        flush;
    logic [33:0] pmp_addr;
    pmp_req_e    pmp_type;
    priv_lvl_e   pmp_priv;
    logic        pmp_err;
    logic        err_en;
    logic [33:0] err_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign pmp_err = err_en && (pmp_addr == err_addr);

    ibex_pmp_chan_arb #(.StarveLimit(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ireq_valid_i (ireq_valid),
        .ireq_ready_o (ireq_ready),
        .ireq_addr_i  (ireq_addr),
        .ireq_priv_i  (PRIV_LVL_U),
        .dreq_valid_i (dreq_valid),
        .dreq_ready_o (dreq_ready),
        .dreq_addr_i  (dreq_addr),
        .dreq_type_i  (dreq_type),
        .dreq_priv_i  (PRIV_LVL_S),
        .dreq_split_i (dreq_split),
        .irsp_valid_o (irsp_valid),
        .irsp_err_o   (irsp_err),
        .drsp_valid_o (drsp_valid),
        .drsp_err_o   (drsp_err),
        .flush_i      (flush),
        .pmp_addr_o   (pmp_addr),
        .pmp_type_o   (pmp_type),
        .pmp_priv_o   (pmp_priv),
        .pmp_err_i    (pmp_err)
    );

    typedef struct {
        logic        iv;  logic [33:0] ia;
        logic        dv;  logic [33:0] da; logic dw; logic ds;
        logic        fl;  logic ee; logic [33:0] ea;
        logic        x_ir; logic x_dr; logic x_irv; logic x_ire; logic x_drv; logic x_dre;
        logic [33:0] x_pa; logic [1:0] x_pt; logic [1:0] x_pp;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string nm, input int tag, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge so inputs can be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ireq_valid = 1'b0; ireq_addr = 34'd0;
        dreq_valid = 1'b0; dreq_addr = 34'd0; dreq_type = PMP_ACC_READ; dreq_split = 1'b0;
        flush = 1'b0; err_en = 1'b0; err_addr = 34'd0;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();

        //          iv  ia            dv  da                 dw    ds    fl    ee    ea                  ir    dr    irv   ire   drv   dre   pa                 pt  pp
        vecs[0]  = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           RD, PM};
        vecs[1]  = '{1'b1, 34'h1000, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           RD, PM};
        vecs[2]  = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h1000,        EX, PU};
        vecs[3]  = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 34'h1000,        EX, PU};
        vecs[4]  = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h1000,        EX, PU};
        vecs[5]  = '{1'b0, 34'h0,    1'b1, 34'h0FFE,        1'b1, 1'b1, 1'b0, 1'b1, 34'h1000,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 34'h1000,        EX, PU};
        vecs[6]  = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b1, 34'h1000,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0FFE,        WR, PS};
        vecs[7]  = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b1, 34'h1000,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h1000,        WR, PS};
        vecs[8]  = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 34'h1000,        WR, PS};
        vecs[9]  = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h1000,        WR, PS};
        vecs[10] = '{1'b0, 34'h0,    1'b1, 34'h3_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 34'h3_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 34'h1000,        WR, PS};
        vecs[11] = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b1, 34'h3_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h3_FFFF_FFFE, RD, PS};
        vecs[12] = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b1, 34'h3_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           RD, PS};
        vecs[13] = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 34'h0,           RD, PS};
        vecs[14] = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           RD, PS};
        vecs[15] = '{1'b0, 34'h0,    1'b1, 34'h2000,        1'b0, 1'b0, 1'b0, 1'b1, 34'h2000,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           RD, PS};
        vecs[16] = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b1, 34'h2000,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h2000,        RD, PS};
        vecs[17] = '{1'b1, 34'h3000, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b1, 34'h3000,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 34'h2000,        RD, PS};
        vecs[18] = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b1, 34'h3000,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h3000,        EX, PU};
        vecs[19] = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 34'h3000,        EX, PU};
        vecs[20] = '{1'b0, 34'h0,    1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 34'h0,           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 34'h3000,        EX, PU};

        // ---------------- table-driven vectors ----------------
        do_reset();
        for (int r = 0; r < 21; r++) begin
            if (r > 0) tick();
            ireq_valid = vecs[r].iv; ireq_addr = vecs[r].ia;
            dreq_valid = vecs[r].dv; dreq_addr = vecs[r].da;
            dreq_type  = vecs[r].dw ? PMP_ACC_WRITE : PMP_ACC_READ;
            dreq_split = vecs[r].ds; flush = vecs[r].fl;
            err_en     = vecs[r].ee; err_addr = vecs[r].ea;
            #3;
            chk("ireq_ready", r, {33'd0, ireq_ready}, {33'd0, vecs[r].x_ir});
            chk("dreq_ready", r, {33'd0, dreq_ready}, {33'd0, vecs[r].x_dr});
            chk("irsp_valid", r, {33'd0, irsp_valid}, {33'd0, vecs[r].x_irv});
            chk("irsp_err",   r, {33'd0, irsp_err},   {33'd0, vecs[r].x_ire});
            chk("drsp_valid", r, {33'd0, drsp_valid}, {33'd0, vecs[r].x_drv});
            chk("drsp_err",   r, {33'd0, drsp_err},   {33'd0, vecs[r].x_dre});
            chk("pmp_addr",   r, pmp_addr,            vecs[r].x_pa);
            chk("pmp_type",   r, {32'd0, pmp_type},   {32'd0, vecs[r].x_pt});
            chk("pmp_priv",   r, {32'd0, pmp_priv},   {32'd0, vecs[r].x_pp});
        end

        // ---------------- round-robin with both requesters always valid ----------------
        do_reset();
        ireq_valid = 1'b1; ireq_addr = 34'h400;
        dreq_valid = 1'b1; dreq_addr = 34'h500;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            #3;
            if ((c % 2) == 0) begin
                chk("rr_igrant", c, {33'd0, ireq_ready}, {33'd0, ((c / 2) % 2) == 0});
                chk("rr_dgrant", c, {33'd0, dreq_ready}, {33'd0, ((c / 2) % 2) == 1});
                if (c > 0) begin
                    chk("rr_irsp", c, {33'd0, irsp_valid}, {33'd0, ((c / 2) % 2) == 1});
                    chk("rr_drsp", c, {33'd0, drsp_valid}, {33'd0, ((c / 2) % 2) == 0});
                end
            end else begin
                chk("rr_noready", c, {32'd0, ireq_ready, dreq_ready}, 34'd0);
            end
        end

        // ---------------- intermittent I-side: starvation bound ----------------
        begin
            int pend = 0;
            int waitd = 0;
            int maxw = 0;
            int igr = 0;
            do_reset();
            dreq_valid = 1'b1; dreq_addr = 34'h600;
            for (int c = 0; c < 60; c++) begin
                if (c > 0) tick();
                if ((c % 5) == 1 || (c % 7) == 3) pend = 1;
                ireq_valid = (pend != 0); ireq_addr = 34'h700;
                #3;
                if (dreq_ready && ireq_valid) begin
                    waitd++;
                    if (waitd > maxw) maxw = waitd;
                end
                if (ireq_ready) begin
                    waitd = 0;
                    pend = 0;
                    igr++;
                end
            end
            chk("starve_max_dgrants", 0, 34'(maxw <= 2), 34'd1);
            chk("starve_i_granted",   0, 34'(igr > 0),   34'd1);
        end

        // ---------------- flush in CHECK ----------------
        do_reset();
        ireq_valid = 1'b1; ireq_addr = 34'h4000;
        dreq_valid = 1'b1; dreq_addr = 34'h5000;
        #3;
        chk("fl_igrant", 0, {32'd0, ireq_ready, dreq_ready}, 34'b10);
        tick();
        ireq_valid = 1'b0; flush = 1'b1;
        #3;
        chk("fl_check_addr", 1, pmp_addr, 34'h4000);
        chk("fl_check_noready", 1, {32'd0, ireq_ready, dreq_ready}, 34'd0);
        tick();
        flush = 1'b0;
        #3;
        chk("fl_no_irsp", 2, {33'd0, irsp_valid}, 34'd0);
        chk("fl_dgrant_idle", 2, {32'd0, ireq_ready, dreq_ready}, 34'b01);
        tick();
        dreq_valid = 1'b0;
        #3;
        chk("fl_no_irsp", 3, {33'd0, irsp_valid}, 34'd0);
        chk("fl_d_addr", 3, pmp_addr, 34'h5000);
        tick();
        #3;
        chk("fl_drsp", 4, {32'd0, irsp_valid, drsp_valid}, 34'b01);

        // ---------------- reset during CHECK2 ----------------
        do_reset();
        dreq_valid = 1'b1; dreq_addr = 34'h6FFE; dreq_type = PMP_ACC_WRITE; dreq_split = 1'b1;
        err_en = 1'b1; err_addr = 34'h6FFE;
        #3;
        chk("rst_dgrant", 0, {33'd0, dreq_ready}, 34'd1);
        tick();
        dreq_valid = 1'b0;
        #3;
        chk("rst_check_addr", 1, pmp_addr, 34'h6FFE);
        tick();
        rst_i = 1'b1;
        #3;
        chk("rst_check2_addr", 2, pmp_addr, 34'h7000);
        tick();
        rst_i = 1'b0; ireq_valid = 1'b1; ireq_addr = 34'h8000;
        #3;
        chk("rst_no_drsp", 3, {32'd0, drsp_valid, drsp_err}, 34'd0);
        chk("rst_addr", 3, pmp_addr, 34'd0);
        chk("rst_type", 3, {32'd0, pmp_type}, {32'd0, RD});
        chk("rst_priv", 3, {32'd0, pmp_priv}, {32'd0, PM});
        chk("rst_new_grant", 3, {33'd0, ireq_ready}, 34'd1);
        tick();
        ireq_valid = 1'b0;
        #3;
        chk("rst_no_drsp", 4, {33'd0, drsp_valid}, 34'd0);
        chk("rst_new_addr", 4, pmp_addr, 34'h8000);
        tick();
        #3;
        chk("rst_new_irsp", 5, {32'd0, irsp_valid, drsp_valid}, 34'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ibex_pmp_chan_arb.md
# ibex_pmp_chan_arb

Arbitrates and sequences the instruction-fetch and load/store requesters onto a single shared PMP check channel. This lets a core configuration instantiate the PMP checker with one channel instead of one channel per requester. The block accepts one request at a time, drives the checker's address, type and privilege inputs from registered state, and samples the checker's combinational error result. Load/store accesses that cross a word boundary get a second check on the next word, and the two errors are merged into one response.

## Interface
- `StarveLimit` — default 4 — maximum number of consecutive grants to the D-side while an I-side request is waiting; range 1..15.
- `clk_i` — in — 1 — clock; all state updates on the rising edge.
- `rst_i` — in — 1 — synchronous, active-high reset.
- `ireq_valid_i` / `ireq_ready_o` — in / out — 1 / 1 — I-side request handshake; transfer occurs when both are high.
- `ireq_addr_i` — in — 34 — I-side fetch address.
- `ireq_priv_i` — in — `ibex_pkg::priv_lvl_e` — I-side privilege level.
- `dreq_valid_i` / `dreq_ready_o` — in / out — 1 / 1 — D-side request handshake.
- `dreq_addr_i` — in — 34 — D-side access address.
- `dreq_type_i` — in — `ibex_pkg::pmp_req_e` — `PMP_ACC_READ` or `PMP_ACC_WRITE`.
- `dreq_priv_i` — in — `priv_lvl_e` — D-side privilege level.
- `dreq_split_i` — in — 1 — access crosses a word boundary; a second check is required.
- `irsp_valid_o`, `irsp_err_o` — out — 1 each — I-side response pulse and its error flag.
- `drsp_valid_o`, `drsp_err_o` — out — 1 each — D-side response pulse and its error flag.
- `flush_i` — in — 1 — cancels an outstanding I-side check.
- `pmp_addr_o` — out — 34 — address driven to the PMP checker channel.
- `pmp_type_o` — out — `pmp_req_e` — access type driven to the checker.
- `pmp_priv_o` — out — `priv_lvl_e` — privilege level driven to the checker.
- `pmp_err_i` — in — 1 — combinational error result from the checker for the current `pmp_*_o` values.

## Operation
- FSM states: IDLE, CHECK, CHECK2, RESP. Reset state is IDLE.
- Grant:
  - Requests are granted only in IDLE or RESP.
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, round-robin applies: the requester not granted last wins.
  - Override: when the D-side has been granted `StarveLimit` consecutive times while `ireq_valid_i` was high, the I-side wins the next grant.
  - `*_ready_o` is high only for the granted requester in that cycle. Ready may depend combinationally on valid.
- Accept:
  - Latch address, type, privilege, split flag and owner. Go to CHECK.
  - I-side type is always `PMP_ACC_EXEC`. The I-side split flag is forced to 0.
- CHECK:
  - `pmp_*_o` reflect the latched request.
  - `err_q <= pmp_err_i`.
  - If split, go to CHECK2 and set the latched address to `{addr[33:2]+1, 2'b00}`. The word index wraps from `34'h3_FFFF_FFFC` to 0.
  - If not split, go to RESP.
- CHECK2: `err_q <= err_q | pmp_err_i`; go to RESP.
- RESP:
  - `*rsp_valid_o` is high for exactly one cycle for the owner, with `*rsp_err_o = err_q`.
  - A new grant in the same cycle goes to CHECK; otherwise go to IDLE.
  - Responses have no backpressure.
- Flush:
  - `flush_i` while the I-side owns the operation in CHECK or CHECK2: go to IDLE next cycle; no I-side response is emitted.
  - `flush_i` in RESP does not suppress the response.
  - `flush_i` is ignored in IDLE and when the D-side owns the operation; it never blocks new grants.
- Outside CHECK/CHECK2, `pmp_*_o` hold the last latched values. The checker result is don't-care there.

## Timing
- Reset values:
  - state IDLE, last-grant = D-side (the I-side wins the first tie), starve counter 0, `err_q` 0.
  - Latched address 0, type `PMP_ACC_READ`, privilege `PRIV_LVL_M`.
  - All `*rsp_valid_o` and `*rsp_err_o` are 0.
- Latency, with accept in cycle N:
  - Non-split: CHECK in N+1, response in N+2.
  - Split: CHECK in N+1, CHECK2 in N+2, response in N+3.
- Throughput: back-to-back grants in RESP give one non-split check every 2 cycles.
- `rst_i` asserted mid-operation: the FSM returns to IDLE on the next edge. The outstanding request is dropped with no response.
- Starve counter:
  - Increments on a D-side grant while `ireq_valid_i` is high.
  - Clears on any I-side grant, or on a D-side grant made while `ireq_valid_i` is low.
  - Saturates at `StarveLimit`.

## Test plan
- Single I-request, addr 0x1000, `pmp_err_i`=0: `ireq_ready_o`=1 in cycle 0, `irsp_valid_o`=1 with err=0 in cycle 2, and `pmp_type_o`=EXEC in cycle 1.
- Split D-write, addr 0x0FFE, with the checker returning err=0 for 0x0FFE and err=1 for 0x1000: `pmp_addr_o`=0x0FFE in cycle 1 and 0x1000 in cycle 2; `drsp_valid_o`=1 with err=1 in cycle 3.
- Split wrap, addr `34'h3_FFFF_FFFE`: the second check drives `pmp_addr_o`=0. The response arrives 3 cycles after accept.
- Both requesters continuously valid, `StarveLimit`=2, after reset: grant order is I, D, I, D, …, and every RESP cycle also accepts a new request. Separately, with I-side valid only intermittently, at most 2 D-grants occur while I is waiting.
- I-request accepted, then `flush_i` high in CHECK: no `irsp_valid_o` pulse; the block is back in IDLE the next cycle and a pending D-request is granted there.
- `rst_i` pulsed during CHECK2 of a split D-access: no `drsp_valid_o`, all outputs at reset values, and a new request is accepted in the cycle after reset is released.
